// File: rtl/doitgen_operand_packer.sv
// -----------------------------------------------------------------------------
// doitgen_operand_packer
//
// Writer-side front end for the doitgen kernel. A serial stream of ELEM_W-bit
// elements arrives over a valid/ready handshake: first the NR x NQ x NP A
// tensor, then the NP x NP X matrix. Elements are shifted into flat operand
// words, with the first element ending up in the MSBs. The completed pair is
// then presented with its own valid/ready handshake.
//
// Optional feature (macro DOITGEN_PACK_FRAME_CHECK_EN):
//   This adds the in_last input and the frame_err output. An accepted element
//   whose in_last bit does not match "final X element" is dropped. The frame
//   is discarded, and frame_err pulses for one cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (priority over flush)
//   flush      synchronous abort of the current frame
//   in_valid   input element valid
//   in_ready   packer can accept an element (LOAD_A / LOAD_X)
//   in_data    element value
//   in_last    (feature only) marks the final X element of a frame
//   frame_err  (feature only) one-cycle framing error pulse
//   out_valid  a_out/x_out hold a complete frame
//   out_ready  consumer takes the frame
//   a_out      packed A, element [0][0][0] in the MSBs
//   x_out      packed X, element [0][0] in the MSBs
//   elem_cnt   elements accepted in the current frame
// -----------------------------------------------------------------------------
module doitgen_operand_packer #(
    parameter  int ELEM_W = 8,
    parameter  int NR     = 2,
    parameter  int NQ     = 2,
    parameter  int NP     = 2,
    localparam int A_W    = NR * NQ * NP * ELEM_W,
    localparam int X_W    = NP * NP * ELEM_W,
    localparam int CNT_W  = $clog2(NR * NQ * NP + NP * NP + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
    input  logic              in_last,
    output logic              frame_err,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [A_W-1:0]    a_out,
    output logic [X_W-1:0]    x_out,
    output logic [CNT_W-1:0]  elem_cnt
);

    localparam int A_N = NR * NQ * NP;
    localparam int TOT = A_N + NP * NP;
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(A_N - 1);
    localparam logic [CNT_W-1:0] LAST_X = CNT_W'(TOT - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_X  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t             state_q;
    logic [A_W-1:0]     a_q;
    logic [X_W-1:0]     x_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic               accept;
    logic               framing_ok;

    // in_ready is combinational from the state register. It is held low while
    // reset is asserted, because the state register is not yet defined then.
    assign in_ready = !rst && (state_q != PRESENT);

    // A flush edge swallows whatever element is presented in that cycle.
    assign accept   = in_valid && in_ready && !flush;

`ifdef DOITGEN_PACK_FRAME_CHECK_EN
    logic frame_err_q;

    // in_last must be high on the final X element and low everywhere else.
    assign framing_ok = (in_last == (cnt_q == LAST_X));
    assign frame_err  = frame_err_q;
`else
    assign framing_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            a_q         <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else if (flush) begin
            // Operand registers are intentionally left untouched.
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        if (!framing_ok) begin
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
                            frame_err_q <= 1'b1;
`endif
                            cnt_q   <= '0;
                        end else begin
                            // Shift-in form keeps the first element in the MSBs.
                            a_q     <= (a_q << ELEM_W) | A_W'(in_data);
                            cnt_q   <= cnt_q + 1'b1;
                            if (cnt_q == LAST_A) begin
                                state_q <= LOAD_X;
                            end
                        end
                    end
                end
                LOAD_X: begin
                    if (accept) begin
                        if (!framing_ok) begin
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
                            frame_err_q <= 1'b1;
`endif
                            state_q <= LOAD_A;
                            cnt_q   <= '0;
                        end else begin
                            x_q     <= (x_q << ELEM_W) | X_W'(in_data);
                            cnt_q   <= cnt_q + 1'b1;
                            if (cnt_q == LAST_X) begin
                                state_q     <= PRESENT;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                PRESENT: begin
                    // out_valid_q is always set in this state.
                    if (out_ready) begin
                        state_q     <= LOAD_A;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= LOAD_A;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign a_out     = a_q;
    assign x_out     = x_q;
    assign elem_cnt  = cnt_q;

endmodule

// File: tb/tb_doitgen_operand_packer.sv
module tb_doitgen_operand_packer;

    localparam int TOT = 12;
    localparam int A_N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] a_out;
    logic [31:0] x_out;
    logic [3:0]  elem_cnt;
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
    logic        frame_err;
`endif

    doitgen_operand_packer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef DOITGEN_PACK_FRAME_CHECK_EN
        .in_last   (in_last),
        .frame_err (frame_err),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .x_out     (x_out),
        .elem_cnt  (elem_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [95:0] elems;   // element 0 in the MSBs
        logic [63:0] exp_a;
        logic [31:0] exp_x;
    } frame_vec_t;

    frame_vec_t vt[4];

    // Behavioural model: list of bytes accepted in the current frame.
    logic [7:0] mq[$];
    logic       pres;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [95:0] e);
        for (int i = 0; i < TOT; i++) send_elem(e[95-8*i -: 8], i == TOT - 1);
    endtask

    task automatic check_frame(input string tag, input logic [63:0] ea, input logic [31:0] ex);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_a_out"}, a_out, ea);
        chk({tag, "_x_out"}, 64'(x_out), 64'(ex));
        chk({tag, "_elem_cnt"}, 64'(elem_cnt), 64'(TOT));
        $display("frame %s: a_out=%h x_out=%h", tag, a_out, x_out);
    endtask

    function automatic logic [63:0] model_a();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < A_N; i++) r[63-8*i -: 8] = mq[i];
        return r;
    endfunction

    function automatic logic [31:0] model_x();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < TOT - A_N; i++) r[31-8*i -: 8] = mq[A_N+i];
        return r;
    endfunction

    initial begin
        vt[0] = '{96'h0102030405060708_10203040, 64'h0102030405060708, 32'h10203040};
        vt[1] = '{96'hA0A1A2A3A4A5A6A7_A8A9AAAB, 64'hA0A1A2A3A4A5A6A7, 32'hA8A9AAAB};
        vt[2] = '{96'h1122334455667788_99AABBCC, 64'h1122334455667788, 32'h99AABBCC};
        vt[3] = '{96'hFEDCBA9876543210_0F1E2D3C, 64'hFEDCBA9876543210, 32'h0F1E2D3C};

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_a_out", a_out, 64'd0);
        chk("rst_x_out", 64'(x_out), 64'd0);
        chk("rst_elem_cnt", 64'(elem_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven frames with out_ready held high
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send_frame(vt[v].elems);
            check_frame($sformatf("tbl%0d", v), vt[v].exp_a, vt[v].exp_x);
            tick();
            chk("tbl_out_valid_drop", 64'(out_valid), 64'd0);
            chk("tbl_in_ready_back", 64'(in_ready), 64'd1);
            chk("tbl_cnt_clear", 64'(elem_cnt), 64'd0);
        end

        // Back-pressure: frame held while the consumer stalls
        out_ready = 1'b0;
        send_frame(vt[2].elems);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            check_frame($sformatf("stall%0d", c), vt[2].exp_a, vt[2].exp_x);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release_out_valid", 64'(out_valid), 64'd0);
        chk("stall_release_cnt", 64'(elem_cnt), 64'd0);

        // Flush after 5 accepts
        for (int i = 0; i < 5; i++) send_elem(8'h30 + 8'(i), 1'b0);
        chk("preflush_cnt", 64'(elem_cnt), 64'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_cnt", 64'(elem_cnt), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        send_frame(vt[1].elems);
        check_frame("after_flush", vt[1].exp_a, vt[1].exp_x);
        tick();

        // Reset mid-frame after 10 accepts
        for (int i = 0; i < 10; i++) send_elem(8'h60 + 8'(i), 1'b0);
        chk("prerst_cnt", 64'(elem_cnt), 64'd10);
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_a_out", a_out, 64'd0);
        chk("midrst_x_out", 64'(x_out), 64'd0);
        chk("midrst_cnt", 64'(elem_cnt), 64'd0);
        rst = 1'b0;
        #1;
        send_frame(vt[3].elems);
        check_frame("after_rst", vt[3].exp_a, vt[3].exp_x);
        tick();

        // Back-to-back streaming: frames every TOT+1 cycles
        begin
            logic [7:0]  seq[24];
            logic [63:0] ea;
            logic [31:0] ex;
            int k, cyc, nr;
            int rise[2];
            logic acc;
            for (int i = 0; i < 24; i++) seq[i] = 8'hC0 + 8'(i);
            k = 0; cyc = 0; nr = 0;
            rise[0] = 0; rise[1] = 0;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            while (nr < 2 && cyc < 100) begin
                in_data = (k < 24) ? seq[k] : 8'h00;
                acc = in_ready;
                tick();
                cyc++;
                if (acc && k < 24) k++;
                if (out_valid) begin
                    rise[nr] = cyc;
                    ea = '0;
                    ex = '0;
                    for (int i = 0; i < A_N; i++) ea[63-8*i -: 8] = seq[12*nr+i];
                    for (int i = 0; i < 4; i++) ex[31-8*i -: 8] = seq[12*nr+A_N+i];
                    check_frame($sformatf("b2b%0d", nr), ea, ex);
                    nr++;
                end
            end
            in_valid = 1'b0;
            chk("b2b_frames_seen", 64'(nr), 64'd2);
            chk("b2b_spacing", 64'(rise[1] - rise[0]), 64'(TOT + 1));
            tick();
        end

`ifdef DOITGEN_PACK_FRAME_CHECK_EN
        // Framing error: in_last on element 7
        for (int i = 0; i < 6; i++) send_elem(8'h70 + 8'(i), 1'b0);
        send_elem(8'h76, 1'b1);
        chk("ferr_pulse", 64'(frame_err), 64'd1);
        chk("ferr_cnt", 64'(elem_cnt), 64'd0);
        chk("ferr_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("ferr_pulse_end", 64'(frame_err), 64'd0);
        send_frame(vt[0].elems);
        check_frame("after_ferr", vt[0].exp_a, vt[0].exp_x);
        chk("ferr_quiet", 64'(frame_err), 64'd0);
        tick();
`endif

        // Randomized traffic against the queue model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq.delete();
        pres = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic acc;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            in_last   = (mq.size() == TOT - 1);
            acc = in_valid && !pres && !flush;
            tick();
            if (flush) begin
                mq.delete();
                pres = 1'b0;
            end else if (pres && out_ready) begin
                mq.delete();
                pres = 1'b0;
            end else if (acc) begin
                mq.push_back(in_data);
                if (mq.size() == TOT) pres = 1'b1;
            end
            chk("rnd_out_valid", 64'(out_valid), 64'(pres));
            chk("rnd_in_ready", 64'(in_ready), 64'(!pres));
            chk("rnd_elem_cnt", 64'(elem_cnt), 64'(mq.size()));
            if (pres && out_valid) check_frame($sformatf("rnd@%0d", c), model_a(), model_x());
        end
        flush = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/doitgen_operand_packer.md
Name: doitgen_operand_packer

Overview:
Writer-side front end for the doitgen kernel. Accepts a serial stream of ELEM_W-bit elements over a valid/ready handshake: first the A tensor (NR×NQ×NP elements), then the X matrix (NP×NP elements). Packs them into the flat A and X operand words the kernel consumes, then presents both words with a valid/ready handshake. It sits between the operand source (DMA or testbench) and the doitgen compute block.

Parameters:
ELEM_W, 8, element width in bits
NR, 2, A tensor r dimension
NQ, 2, A tensor q dimension
NP, 2, A tensor p/s dimension and X matrix dimension
A_W, NR*NQ*NP*ELEM_W (derived, localparam), packed A width
X_W, NP*NP*ELEM_W (derived, localparam), packed X width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous abort of the current frame
in_valid  in  1  input element valid
in_ready  out  1  packer accepts an element this cycle
in_data  in  ELEM_W  element value
out_valid  out  1  a_out/x_out hold a complete frame
out_ready  in  1  consumer takes the frame
a_out  out  A_W  packed A; element [0][0][0] in the MSBs, row-major r,q,s order
x_out  out  X_W  packed X; element [0][0] in the MSBs, row-major order
elem_cnt  out  clog2(NR*NQ*NP+NP*NP+1)  number of elements accepted in the current frame

Behaviour:
- Reset (rst=1 at an edge): state=LOAD_A, elem_cnt=0, a_out=0, x_out=0, out_valid=0. in_ready is combinational from state: 0 while rst is asserted, 1 in the cycle after reset releases.
- FSM states: LOAD_A, LOAD_X, PRESENT.
  - in_ready = 1 in LOAD_A and LOAD_X; 0 in PRESENT.
  - out_valid = 1 only in PRESENT (registered).
- Accept: an element is accepted on an edge where in_valid && in_ready.
  - LOAD_A: a_out <= {a_out[A_W-ELEM_W-1:0], in_data}.
  - LOAD_X: x_out <= {x_out[X_W-ELEM_W-1:0], in_data}.
  - elem_cnt increments on every accept.
- Transitions:
  - LOAD_A -> LOAD_X on the accept that makes elem_cnt reach NR*NQ*NP.
  - LOAD_X -> PRESENT on the accept of the final X element. out_valid rises the next cycle, so latency is 1 cycle from the last accept.
  - PRESENT -> LOAD_A on an edge where out_valid && out_ready; elem_cnt clears to 0.
- Stability: while out_valid=1 and out_ready=0, a_out, x_out and elem_cnt hold stable. in_valid is ignored.
- Register contents during loading: a_out/x_out are not cleared between frames. Partial contents during LOAD_* are don't-care to the consumer.
- Throughput: with in_valid and out_ready held at 1, one frame completes every NR*NQ*NP+NP*NP+1 cycles.
- Flush: flush=1 at an edge forces state=LOAD_A, elem_cnt=0, out_valid=0. Any element presented that cycle is not accepted.
  - Flush has priority over a simultaneous accept or output handshake.
  - a_out/x_out are not cleared by flush.
- Reset has priority over flush. Reset mid-frame discards the partial frame.
- No arithmetic is performed; elements are passed bit-exact.

Optional Feature:
Macro: DOITGEN_PACK_FRAME_CHECK_EN.
- With the macro defined, the block adds input in_last (1 bit) and output frame_err (1 bit, reset 0).
- in_last must be 1 exactly on the final X element of a frame.
- On an accepted element where in_last does not match that position:
  - frame_err pulses high for exactly one cycle (the following cycle).
  - The element is dropped, the frame is discarded, and state returns to LOAD_A with elem_cnt=0.
- Without the macro, neither port exists and framing is by count only.

Test Plan:
1. Defaults; stream 0x01..0x08 then 0x10,0x20,0x30,0x40 with out_ready=1 -> one cycle after 12th accept out_valid=1, a_out=64'h0102030405060708, x_out=32'h10203040; next cycle out_valid=0, in_ready=1.
2. Complete a frame with out_ready=0 for 5 cycles while in_valid=1, in_data=0xFF -> out_valid stays 1, in_ready=0, a_out/x_out/elem_cnt unchanged; raise out_ready -> handshake, elem_cnt=0.
3. Accept 5 elements, assert flush one cycle with in_valid=1 -> elem_cnt=0, state LOAD_A; stream 12 fresh bytes 0xA0..0xAB -> a_out=64'hA0A1A2A3A4A5A6A7, x_out=32'hA8A9AAAB.
4. Assert rst after 10 accepts -> out_valid=0, a_out=0, x_out=0, elem_cnt=0; next full frame packs correctly.
5. in_valid and out_ready tied 1, two back-to-back frames -> out_valid pulses exactly 13 cycles apart, both frames correct.
6. With DOITGEN_PACK_FRAME_CHECK_EN: assert in_last on element 7 -> frame_err=1 for one cycle, elem_cnt=0, no out_valid. Then a correct frame with in_last on element 12 -> out_valid=1 and frame_err stays 0.
